// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Control FSM for a small multicycle datapath. One instruction is accepted in
// IDLE, decoded, executed, optionally sent through a memory access with a
// bounded wait, written back, and counted as retired. Illegal opcodes and
// memory timeouts divert through a one-cycle TRAP state.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   instr_valid  opcode is valid this cycle (only looked at in IDLE)
//   opcode       instruction opcode
//   mem_ready    memory completes the current access
//   instr_ready  high in IDLE: the unit will accept an opcode this cycle
//   regDst, aluSrc, memToReg, aluOp
//                decoded datapath controls, registered in DECODE and held
//                until the unit returns to IDLE
//   branch       BEQ resolve strobe, EXECUTE only
//   regWrite     WRITEBACK strobe
//   memRead      LOAD strobe, every MEM cycle until mem_ready
//   memWrite     STORE strobe, every MEM cycle until mem_ready
//   state        current FSM state code
//   trap         one-cycle error pulse (TRAP state)
//   trap_cause   01 illegal opcode, 10 memory timeout; held until next trap
//   retired      completed-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int                   OPCODE_W    = 6,
    parameter int                   ALUOP_W     = 4,
    parameter int                   CNT_W       = 16,
    parameter int                   MEM_TIMEOUT = 15,
    parameter logic [OPCODE_W-1:0]  OP_ADD      = 6'b011111,
    parameter logic [OPCODE_W-1:0]  OP_SUB      = 6'b011110,
    parameter logic [OPCODE_W-1:0]  OP_MUL      = 6'b011101,
    parameter logic [OPCODE_W-1:0]  OP_DIV      = 6'b011100,
    parameter logic [OPCODE_W-1:0]  OP_LOAD     = 6'b100001,
    parameter logic [OPCODE_W-1:0]  OP_STORE    = 6'b101010,
    parameter logic [OPCODE_W-1:0]  OP_BEQ      = 6'b000100
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                instr_ready,
    output logic                regDst,
    output logic                aluSrc,
    output logic                memToReg,
    output logic                branch,
    output logic                regWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic [2:0]          state,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    retired
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd5;

    // The wait counter only ever needs to reach MEM_TIMEOUT-1.
    localparam int TMO_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    logic [OPCODE_W-1:0] latchedOpcode;
    logic [TMO_W-1:0]    memWaitCnt;
    logic [2:0]          nextState;
    logic                isLoad, isStore, isBeq;

    logic                decLegal, decRegDst, decAluSrc, decMemToReg;
    logic                decLoad, decStore, decBeq;
    logic [ALUOP_W-1:0]  decAluOp;
    logic                memTimeout, retireEvent;

    // Decode of the opcode captured in IDLE.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        decLegal    = 1'b1;
        decRegDst   = 1'b0;
        decAluSrc   = 1'b0;
        decMemToReg = 1'b0;
        decAluOp    = '0;
        decLoad     = 1'b0;
        decStore    = 1'b0;
        decBeq      = 1'b0;
        case (latchedOpcode)
            OP_ADD:   decRegDst = 1'b1;
            OP_SUB:   begin decRegDst = 1'b1; decAluOp = ALUOP_W'(1); end
            OP_MUL:   begin decRegDst = 1'b1; decAluOp = ALUOP_W'(2); end
            OP_DIV:   begin decRegDst = 1'b1; decAluOp = ALUOP_W'(3); end
            OP_LOAD:  begin decAluSrc = 1'b1; decMemToReg = 1'b1; decLoad = 1'b1; end
            OP_STORE: begin decAluSrc = 1'b1; decStore = 1'b1; end
            OP_BEQ:   begin decAluOp = ALUOP_W'(1); decBeq = 1'b1; end
            default:  decLegal = 1'b0;
        endcase
    end

    // mem_ready in the last allowed cycle still completes the access.
    assign memTimeout = (memWaitCnt == TMO_LAST);

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:      if (instr_valid) nextState = S_DECODE;
            S_DECODE:    nextState = decLegal ? S_EXECUTE : S_TRAP;
            S_EXECUTE: begin
                if (isLoad || isStore) nextState = S_MEM;
                else if (isBeq)        nextState = S_IDLE;
                else                   nextState = S_WRITEBACK;
            end
            S_MEM: begin
                if (mem_ready)       nextState = isLoad ? S_WRITEBACK : S_IDLE;
                else if (memTimeout) nextState = S_TRAP;
            end
            S_WRITEBACK: nextState = S_IDLE;
            S_TRAP:      nextState = S_IDLE;
            default:     nextState = S_IDLE;   // unused codes 6-7 recover
        endcase
    end

    assign retireEvent = ((state == S_EXECUTE) && isBeq) ||
                         ((state == S_MEM) && mem_ready && isStore) ||
                         (state == S_WRITEBACK);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the values from before this edge.
        if (reset) begin
            state         <= S_IDLE;
            latchedOpcode <= '0;
            memWaitCnt    <= '0;
            trap_cause    <= 2'b00;
            retired       <= '0;
            regDst        <= 1'b0;
            aluSrc        <= 1'b0;
            memToReg      <= 1'b0;
            aluOp         <= '0;
            isLoad        <= 1'b0;
            isStore       <= 1'b0;
            isBeq         <= 1'b0;
        end else begin
            state <= nextState;

            if ((state == S_IDLE) && instr_valid)
                latchedOpcode <= opcode;

            // Counter restarts whenever MEM is (re)entered.
            if (state != S_MEM)
                memWaitCnt <= '0;
            else if (!mem_ready && !memTimeout)
                memWaitCnt <= memWaitCnt + TMO_W'(1);

            if ((state == S_DECODE) && !decLegal)
                trap_cause <= 2'b01;
            else if ((state == S_MEM) && !mem_ready && memTimeout)
                trap_cause <= 2'b10;

            if (retireEvent)
                retired <= retired + CNT_W'(1);

            // Decoded controls live from DECODE until the return to IDLE;
            // an illegal opcode leaves them at their cleared value.
            if (nextState == S_IDLE) begin
                regDst   <= 1'b0;
                aluSrc   <= 1'b0;
                memToReg <= 1'b0;
                aluOp    <= '0;
                isLoad   <= 1'b0;
                isStore  <= 1'b0;
                isBeq    <= 1'b0;
            end else if ((state == S_DECODE) && decLegal) begin
                regDst   <= decRegDst;
                aluSrc   <= decAluSrc;
                memToReg <= decMemToReg;
                aluOp    <= decAluOp;
                isLoad   <= decLoad;
                isStore  <= decStore;
                isBeq    <= decBeq;
            end
        end
    end

    assign instr_ready = (state == S_IDLE);
    assign regWrite    = (state == S_WRITEBACK);
    assign memRead     = (state == S_MEM) && isLoad;
    assign memWrite    = (state == S_MEM) && isStore;
    assign branch      = (state == S_EXECUTE) && isBeq;
    assign trap        = (state == S_TRAP);

endmodule

// File: tb/tb_multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_unit
//
// Self-checking bench. The reference model turns each instruction into the
// list of states it should visit (derived from opcode class and how long
// memory keeps mem_ready low), then derives every strobe, trap_cause and the
// retired count from that list. Inputs change on the falling edge; outputs
// are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_multicycle_control_unit;

    localparam int CW  = 4;
    localparam int TMO = 15;

    localparam logic [5:0] OP_ADD   = 6'b011111;
    localparam logic [5:0] OP_SUB   = 6'b011110;
    localparam logic [5:0] OP_MUL   = 6'b011101;
    localparam logic [5:0] OP_DIV   = 6'b011100;
    localparam logic [5:0] OP_LOAD  = 6'b100001;
    localparam logic [5:0] OP_STORE = 6'b101010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int CL_ALU = 0, CL_LOAD = 1, CL_STORE = 2, CL_BEQ = 3, CL_BAD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          instr_valid = 1'b0;
    logic [5:0]    opcode = '0;
    logic          mem_ready = 1'b0;
    logic          instr_ready, regDst, aluSrc, memToReg, branch;
    logic          regWrite, memRead, memWrite, trap;
    logic [3:0]    aluOp;
    logic [2:0]    state;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired;

    int         total = 0;
    int         bad = 0;
    int         expRetired = 0;
    logic [1:0] expCause = 2'b00;

    logic [14:0] obs;
    logic [6:0]  ctrlObs;
    assign obs     = {state, instr_ready, regWrite, memRead, memWrite, branch, trap, trap_cause, retired};
    assign ctrlObs = {regDst, aluSrc, memToReg, aluOp};

    multicycle_control_unit #(.CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .mem_ready(mem_ready), .instr_ready(instr_ready), .regDst(regDst),
        .aluSrc(aluSrc), .memToReg(memToReg), .branch(branch), .regWrite(regWrite),
        .memRead(memRead), .memWrite(memWrite), .aluOp(aluOp), .state(state),
        .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Opcode class and expected {regDst, aluSrc, memToReg, aluOp}.
    function automatic int classify(input logic [5:0] op, output logic [6:0] ctrl);
        case (op)
            OP_ADD:   begin ctrl = {3'b100, 4'd0}; return CL_ALU;   end
            OP_SUB:   begin ctrl = {3'b100, 4'd1}; return CL_ALU;   end
            OP_MUL:   begin ctrl = {3'b100, 4'd2}; return CL_ALU;   end
            OP_DIV:   begin ctrl = {3'b100, 4'd3}; return CL_ALU;   end
            OP_LOAD:  begin ctrl = {3'b011, 4'd0}; return CL_LOAD;  end
            OP_STORE: begin ctrl = {3'b010, 4'd0}; return CL_STORE; end
            OP_BEQ:   begin ctrl = {3'b000, 4'd1}; return CL_BEQ;   end
            default:  begin ctrl = 7'd0;           return CL_BAD;   end
        endcase
    endfunction

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 9))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_MUL;
            3: return OP_DIV;
            4: return OP_LOAD;
            5: return OP_STORE;
            6: return OP_BEQ;
            default: return 6'($urandom);
        endcase
    endfunction

    // Idle cycles: nothing offered, unit must sit in IDLE with strobes low.
    task automatic run_idle(input string tag, input int n);
        logic [14:0] expVec;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            opcode      = 6'($urandom);
            mem_ready   = 1'($urandom_range(0, 1));
            expVec = {3'd0, 1'b1, 5'b00000, expCause, 4'(expRetired)};
            #1;
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("FAIL %s idle%0d got=%h want=%h", tag, i, obs, expVec);
            end
        end
    endtask

    // One instruction, accepted in the first cycle. w = number of MEM cycles
    // with mem_ready low before it rises (w >= TMO means it never rises).
    task automatic run_instr(input string tag, input logic [5:0] op, input int w);
        logic [6:0]  ctrl;
        logic [6:0]  expCtrl;
        logic [14:0] expVec;
        int          cls, s, memIdx, memSlots;
        int          seq[$];
        cls = classify(op, ctrl);
        seq = {0, 1};
        case (cls)
            CL_BAD: seq.push_back(5);
            CL_BEQ: seq.push_back(2);
            CL_ALU: begin seq.push_back(2); seq.push_back(4); end
            default: begin
                seq.push_back(2);
                memSlots = (w < TMO) ? w + 1 : TMO;
                for (int k = 0; k < memSlots; k++) seq.push_back(3);
                if (w >= TMO)           seq.push_back(5);
                else if (cls == CL_LOAD) seq.push_back(4);
            end
        endcase
        memIdx = 0;
        foreach (seq[i]) begin
            s = seq[i];
            @(negedge clk);
            instr_valid = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            opcode      = (i == 0) ? op : 6'($urandom);
            mem_ready   = (s == 3) ? (memIdx == w) : 1'($urandom_range(0, 1));
            if (s == 3) memIdx++;
            if (s == 5) expCause = (cls == CL_BAD) ? 2'b01 : 2'b10;
            expVec = {3'(s), s == 0, s == 4, s == 3 && cls == CL_LOAD,
                      s == 3 && cls == CL_STORE, s == 2 && cls == CL_BEQ, s == 5,
                      expCause, 4'(expRetired)};
            #1;
            total++;
            if (obs !== expVec) begin
                bad++;
                $display("FAIL %s cyc%0d outputs got=%h want=%h", tag, i, obs, expVec);
            end
            if ((s >= 2 && s <= 4) || (s == 5 && cls == CL_BAD)) begin
                expCtrl = (cls == CL_BAD) ? 7'd0 : ctrl;
                total++;
                if (ctrlObs !== expCtrl) begin
                    bad++;
                    $display("FAIL %s cyc%0d controls got=%h want=%h", tag, i, ctrlObs, expCtrl);
                end
            end
        end
        if (cls == CL_ALU || cls == CL_BEQ || ((cls == CL_LOAD || cls == CL_STORE) && w < TMO))
            expRetired = (expRetired + 1) % (1 << CW);
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        instr_valid = 1'b1;
        opcode      = OP_LOAD;
        mem_ready   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({state, trap, trap_cause, retired, regWrite, memRead, memWrite, branch, ctrlObs} !== '0) begin
            bad++;
            $display("FAIL reset_values got=%h want=0",
                     {state, trap, trap_cause, retired, regWrite, memRead, memWrite, branch, ctrlObs});
        end
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        #1;
        total++;
        if (instr_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", instr_ready);
        end
        expRetired = 0;
        expCause   = 2'b00;
    endtask

    task automatic test_scenarios();
        run_instr("add", OP_ADD, 0);
        run_idle("after_add", 1);
        run_instr("load_wait3", OP_LOAD, 3);
        run_instr("store_timeout", OP_STORE, 99);
        run_instr("illegal", 6'b111111, 0);
        run_idle("after_illegal", 2);
    endtask

    task automatic test_mem_boundary();
        run_instr("load_last_cycle", OP_LOAD, TMO - 1);
        run_instr("store_last_cycle", OP_STORE, TMO - 1);
        run_instr("load_timeout", OP_LOAD, TMO);
        run_instr("store_now", OP_STORE, 0);
    endtask

    task automatic test_reset_mid_mem();
        run_instr("pre_add", OP_ADD, 0);
        @(negedge clk); instr_valid = 1'b1; opcode = OP_LOAD; mem_ready = 1'b0;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk);                     // EXECUTE
        @(negedge clk);                     // MEM cycle 1
        @(negedge clk); reset = 1'b1;       // MEM cycle 2
        #1;
        total++;
        if ({state, memRead} !== {3'd3, 1'b1}) begin
            bad++;
            $display("FAIL mid_mem_pre got=%h want=%h", {state, memRead}, {3'd3, 1'b1});
        end
        @(negedge clk); reset = 1'b0;
        #1;
        total++;
        if ({state, memRead, retired, trap_cause, instr_ready} !== {3'd0, 1'b0, 4'd0, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL mid_mem_reset got=%h want=%h",
                     {state, memRead, retired, trap_cause, instr_ready}, {3'd0, 1'b0, 4'd0, 2'd0, 1'b1});
        end
        expRetired = 0;
        expCause   = 2'b00;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) run_instr("b2b_add", OP_ADD, 0);
        @(negedge clk); instr_valid = 1'b0;
        #1;
        total++;
        if (retired !== 4'd0) begin
            bad++;
            $display("FAIL wrap retired got=%0d want=0", retired);
        end
        run_instr("beq", OP_BEQ, 0);
        run_idle("after_beq", 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_instr("rand", pick_op(), $urandom_range(0, TMO + 2));
            run_idle("rand_gap", $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_scenarios();
        test_mem_boundary();
        test_reset_mid_mem();
        test_back_to_back();
        test_random();
        run_idle("final", 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 6, meaning opcode width.
REQ-002 SHALL have parameter ALUOP_W, default 4, meaning aluOp width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning retired-instruction counter width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, meaning the maximum number of MEM-state cycles without mem_ready.
REQ-005 SHALL have parameters OP_ADD=011111, OP_SUB=011110, OP_MUL=011101, OP_DIV=011100, OP_LOAD=100001, OP_STORE=101010, OP_BEQ=000100, meaning opcode encodings.
REQ-006 SHALL run on one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous active-high reset.
REQ-009 instr_valid  input  1  opcode is valid this cycle.
REQ-010 opcode  input  OPCODE_W  instruction opcode.
REQ-011 mem_ready  input  1  memory completes the current access.
REQ-012 instr_ready  output  1  unit accepts an opcode this cycle.
REQ-013 regDst, aluSrc, memToReg, branch  output  1 each  datapath controls.
REQ-014 regWrite, memRead, memWrite  output  1 each  state-qualified strobes.
REQ-015 aluOp  output  ALUOP_W  ALU operation select.
REQ-016 state  output  3  current FSM state.
REQ-017 trap  output  1  one-cycle error pulse.
REQ-018 trap_cause  output  2  01 = illegal opcode, 10 = memory timeout, held until the next trap.
REQ-019 retired  output  CNT_W  count of completed instructions.

Function
REQ-020 SHALL implement states IDLE=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5; codes 6-7 SHALL go to IDLE on the next cycle.
REQ-021 In IDLE, instr_ready SHALL be 1; in all other states it SHALL be 0.
REQ-022 IDLE with instr_valid=1 SHALL latch opcode and go to DECODE; IDLE with instr_valid=0 SHALL stay in IDLE.
REQ-023 DECODE SHALL register the decoded controls from the latched opcode and hold them until the next return to IDLE.
REQ-024 ADD, SUB, MUL, DIV SHALL decode to regDst=1, aluSrc=0, memToReg=0, and aluOp=0/1/2/3 respectively.
REQ-025 LOAD SHALL decode to regDst=0, aluSrc=1, memToReg=1, aluOp=0.
REQ-026 STORE SHALL decode to regDst=0, aluSrc=1, memToReg=0, aluOp=0.
REQ-027 BEQ SHALL decode to regDst=0, aluSrc=0, memToReg=0, aluOp=1.
REQ-028 An unlisted opcode SHALL make DECODE go to TRAP with trap_cause=01, with all decoded controls at 0.
REQ-029 EXECUTE SHALL go to WRITEBACK for ALU ops and to MEM for LOAD/STORE.
REQ-030 For BEQ, EXECUTE SHALL assert branch for that cycle only, increment retired, and go to IDLE.
REQ-031 In MEM, memRead (LOAD) or memWrite (STORE) SHALL be held at 1 every cycle until mem_ready.
REQ-032 On mem_ready in MEM, LOAD SHALL go to WRITEBACK, and STORE SHALL go to IDLE and increment retired.
REQ-033 MEM SHALL count cycles with mem_ready=0, cleared on MEM entry.
REQ-034 When that count reaches MEM_TIMEOUT without mem_ready, the unit SHALL go to TRAP with trap_cause=10; mem_ready in the same cycle wins over the timeout.
REQ-035 WRITEBACK SHALL assert regWrite for exactly one cycle, increment retired, and go to IDLE.
REQ-036 TRAP SHALL assert trap for one cycle, go to IDLE, and not increment retired.
REQ-037 regWrite, memRead, memWrite, and branch SHALL be 0 outside the states named in REQ-030 to REQ-035.
REQ-038 retired SHALL wrap modulo 2^CNT_W.
REQ-039 Latency from acceptance in IDLE at cycle N: ALU op in WRITEBACK at N+3 and IDLE at N+4; BEQ in IDLE at N+3.
REQ-040 Latency from acceptance in IDLE at cycle N: LOAD with immediate mem_ready in MEM at N+3, WRITEBACK at N+4, IDLE at N+5.
REQ-041 instr_valid and opcode SHALL be ignored outside IDLE.

Reset
REQ-042 reset=1 at a clock edge SHALL force IDLE from any state, including mid-MEM.
REQ-043 reset SHALL set all control outputs, aluOp, trap, trap_cause, retired, the latched opcode, and the timeout counter to 0.
REQ-044 In the first cycle after reset deasserts, instr_ready SHALL be 1.

Verification
REQ-045 Scenario: ADD 011111 accepted at cycle 0 -> regDst=1, aluOp=0 from cycle 2; regWrite=1 only in cycle 3; retired=1; instr_ready=1 in cycle 4.
REQ-046 Scenario: LOAD with mem_ready low 3 MEM cycles, then high -> memRead=1 for 4 cycles, then one WRITEBACK cycle with regWrite=1 and memToReg=1.
REQ-047 Scenario: STORE with mem_ready never high, MEM_TIMEOUT=15 -> memWrite high 15 cycles, then trap=1 with trap_cause=10, then IDLE; retired unchanged; regWrite never 1.
REQ-048 Scenario: opcode 111111 -> TRAP the cycle after DECODE, trap_cause=01, no strobes asserted.
REQ-049 Scenario: reset asserted on the 2nd MEM cycle of a LOAD -> next cycle state=0, memRead=0, retired=0.
REQ-050 Scenario: CNT_W=4 with 16 back-to-back ADDs -> retired wraps to 0 after the 16th; BEQ gives branch=1 for one cycle and no regWrite.
